laser_dose_ctrl: RTL and testbench
==================================

LASER_DOSE_CTRL -- requirements
Module: laser_dose_ctrl

Interface
REQ-001 SHALL have parameter COOL_CYC, default 8, mandatory laser-off cycles after every pulse (legal 1..255).
REQ-002 SHALL have port Clk, input, 1, single system clock; all state updates on rising edge.
REQ-003 SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port B, input, 2, per-requester start buttons, level-sampled (B[0] console, B[1] foot pedal).
REQ-005 SHALL have port Dur, input, 4, pulse length code; on-time = Dur+1 cycles (1..16).
REQ-006 SHALL have port X, output, 1, laser enable.
REQ-007 SHALL have port Gnt, output, 2, one-hot owner of current pulse; 2'b00 when IDLE.
REQ-008 SHALL have port Busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port Done, output, 1, one-cycle pulse on normal pulse completion.

Function
REQ-010 SHALL implement states IDLE, ON, COOL; all outputs registered.
REQ-011 IDLE: X=0, Gnt=0; if any B bit high at an edge, SHALL grant, latch Dur, and enter ON; X rises the cycle after B sampled.
REQ-012 Only one requester high SHALL be granted directly.
REQ-013 Both high SHALL grant the requester not granted last (round-robin); pointer updates only on a grant.
REQ-014 ON: X=1 for exactly latched Dur+1 cycles, then COOL; Dur changes during ON SHALL be ignored.
REQ-015 Done SHALL pulse high in the first COOL cycle after a normal ON completion.
REQ-016 COOL: X=0, Gnt held, for exactly COOL_CYC cycles, then IDLE.
REQ-017 B activity during ON or COOL SHALL be ignored, not queued; a B held through COOL is granted in the first IDLE cycle.
REQ-018 X SHALL never be high outside ON; at most one Gnt bit high at any time.
REQ-019 Cycle counter SHALL be 8 bits, loaded on entry to ON/COOL, decremented to zero; no wrap-around.

Reset
REQ-020 Rst low SHALL force IDLE, X=0, Gnt=0, Busy=0, Done=0, counter=0, round-robin pointer favouring B[0], immediately and asynchronously.
REQ-021 Reset mid-ON SHALL drop X without a Done pulse or COOL period; first grant after release follows REQ-011.

Configuration
REQ-022 Macro LASER_INTERLOCK_EN SHALL, when defined, add input Ilk (1 bit, active-high safety interlock) and output Abort (1 bit).
REQ-023 With LASER_INTERLOCK_EN: Ilk high in IDLE blocks grants; Ilk high in ON forces X=0 next cycle, enters COOL, pulses Abort one cycle, suppresses Done.
REQ-024 Without LASER_INTERLOCK_EN: Ilk and Abort absent; behaviour exactly REQ-010..REQ-021.

Structure
REQ-025 Package laser_pkg SHALL hold state enum (IDLE/ON/COOL), DUR_W=4, CNT_W=8, requester count 2.
REQ-026 Sub-module laser_timer SHALL implement the loadable 8-bit down-counter with zero flag; arbiter and FSM stay in laser_dose_ctrl.

Verification
REQ-027 Dur=15, B=01 one cycle -> X high exactly 16 cycles starting next cycle, Gnt=01, Done one cycle, X low 8 cycles, Busy drops after.
REQ-028 B=11 held, Dur=0 -> grants alternate 01,10,01 with 1-cycle X pulses separated by 8 COOL cycles plus 1 IDLE cycle.
REQ-029 Dur changed 3->9 mid-ON and B toggled during COOL -> pulse stays 4 cycles, no extra pulse.
REQ-030 Rst low in ON cycle 5 of Dur=15 -> X, Gnt, Busy low immediately, no Done; release + B=10 -> normal pulse, Gnt=10.
REQ-031 LASER_INTERLOCK_EN: Ilk high in ON cycle 3 of Dur=7 -> X low next cycle, Abort one cycle, no Done, 8 COOL cycles; Ilk held in IDLE with B=01 -> no grant.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types and sizes for the laser dose controller.
// The optional interlock (LASER_INTERLOCK_EN) is handled in laser_dose_ctrl only.
package laser_pkg;

    localparam int DUR_W = 4;
    localparam int CNT_W = 8;
    localparam int NREQ  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        COOL = 2'd2
    } state_t;

    // Round-robin pick between the two requesters; last_hi=1 means B[1] was granted last.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic            last_hi);
        logic [NREQ-1:0] pick;
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_hi ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/laser_timer.sv
// Loadable 8-bit down-counter with a zero flag; saturates at zero instead of wrapping.
module laser_timer
    import laser_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/laser_dose_ctrl.sv
// Laser pulse controller: two-requester round-robin arbiter, IDLE/ON/COOL FSM, registered outputs.
// Define LASER_INTERLOCK_EN to add the Ilk safety interlock input and the Abort output.
module laser_dose_ctrl
    import laser_pkg::*;
#(
    parameter int COOL_CYC = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [NREQ-1:0]  B,
    input  logic [DUR_W-1:0] Dur,
`ifdef LASER_INTERLOCK_EN
    input  logic             Ilk,
    output logic             Abort,
`endif
    output logic             X,
    output logic [NREQ-1:0]  Gnt,
    output logic             Busy,
    output logic             Done
);

    // The counter holds "cycles remaining after this one", so loads are length minus one.
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYC - 1);

    state_t           state;
    logic             last_hi;
    logic [NREQ-1:0]  grant;
    logic             start;
    logic             trip;
    logic             zero;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             dec;

    always_comb begin
        grant = rr_pick(B, last_hi);
`ifdef LASER_INTERLOCK_EN
        start = (|B) && !Ilk;
        trip  = Ilk;
`else
        start = |B;
        trip  = 1'b0;
`endif
    end

    always_comb begin
        load     = 1'b0;
        load_val = '0;
        dec      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    load_val = CNT_W'(Dur);
                end
            end
            ON: begin
                if (trip || zero) begin
                    load     = 1'b1;
                    load_val = COOL_LOAD;
                end else begin
                    dec = 1'b1;
                end
            end
            COOL:    dec = 1'b1;
            default: dec = 1'b0;
        endcase
    end

    laser_timer u_timer (
        .clk      (Clk),
        .rst_n    (Rst),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .zero     (zero)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= IDLE;
            X       <= 1'b0;
            Gnt     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            last_hi <= 1'b1;
`ifdef LASER_INTERLOCK_EN
            Abort   <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
`ifdef LASER_INTERLOCK_EN
            Abort <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ON;
                        X       <= 1'b1;
                        Gnt     <= grant;
                        Busy    <= 1'b1;
                        last_hi <= grant[1];
                    end
                end
                ON: begin
                    if (trip) begin
                        state <= COOL;
                        X     <= 1'b0;
`ifdef LASER_INTERLOCK_EN
                        Abort <= 1'b1;
`endif
                    end else if (zero) begin
                        state <= COOL;
                        X     <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                COOL: begin
                    if (zero) begin
                        state <= IDLE;
                        Gnt   <= '0;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    X     <= 1'b0;
                    Gnt   <= '0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_dose_ctrl.sv
// Bench for laser_dose_ctrl: directed scenarios plus random requests against a pulse-timeline model.
// Interlock scenario is compiled in when LASER_INTERLOCK_EN is defined.
module tb_laser_dose_ctrl;

    localparam int COOL = 8;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [1:0] B   = 2'b00;
    logic [3:0] Dur = 4'd0;
    logic       X;
    logic [1:0] Gnt;
    logic       Busy;
    logic       Done;
`ifdef LASER_INTERLOCK_EN
    logic       Ilk = 1'b0;
    logic       Abort;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    laser_dose_ctrl #(.COOL_CYC(COOL)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .B    (B),
        .Dur  (Dur),
`ifdef LASER_INTERLOCK_EN
        .Ilk  (Ilk),
        .Abort(Abort),
`endif
        .X    (X),
        .Gnt  (Gnt),
        .Busy (Busy),
        .Done (Done)
    );

    // Model: one pulse granted at edge ps with length pd+1, then COOL cycles, then idle.
    int         edge_n = 0;
    bit         have_p = 0;
    int         ps = 0;
    int         pd = 0;
    logic [1:0] pg = 2'b00;
    int         last = 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        have_p = 0;
        last   = 1;
    endtask

    // Called at a falling edge: drive inputs, predict, advance one cycle, compare.
    task automatic step(input logic [1:0] b, input logic [3:0] d);
        int         e;
        logic       ex_x, ex_busy, ex_done;
        logic [1:0] ex_g;
        B   = b;
        Dur = d;
        e   = edge_n + 1;
        if ((!have_p || (e - 1 > ps + pd + COOL)) && b != 2'b00) begin
            if (b == 2'b11) pg = (last == 1) ? 2'b01 : 2'b10;
            else            pg = b;
            last   = (pg == 2'b10) ? 1 : 0;
            have_p = 1;
            ps     = e;
            pd     = int'(d);
        end
        @(posedge Clk);
        edge_n = e;
        @(negedge Clk);
        ex_x = 1'b0; ex_busy = 1'b0; ex_done = 1'b0; ex_g = 2'b00;
        if (have_p && e >= ps && e <= ps + pd + COOL) begin
            ex_g    = pg;
            ex_busy = 1'b1;
            ex_x    = (e <= ps + pd);
            ex_done = (e == ps + pd + 1);
        end
        chk("x",    {7'd0, X},    {7'd0, ex_x});
        chk("gnt",  {6'd0, Gnt},  {6'd0, ex_g});
        chk("busy", {7'd0, Busy}, {7'd0, ex_busy});
        chk("done", {7'd0, Done}, {7'd0, ex_done});
    endtask

    initial begin
        int         xcnt;
        int         dcnt;
        logic [1:0] gq[$];
        logic [1:0] prev_x;

        // Reset state
        #2 Rst = 1'b0;
        #1;
        chk("rst_x",    {7'd0, X},    8'd0);
        chk("rst_gnt",  {6'd0, Gnt},  8'd0);
        chk("rst_busy", {7'd0, Busy}, 8'd0);
        chk("rst_done", {7'd0, Done}, 8'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();

        // Both requesters held, single-cycle pulses, alternating grants from reset
        prev_x = 2'b00;
        repeat (32) begin
            step(2'b11, 4'd0);
            if (X && !prev_x[0]) gq.push_back(Gnt);
            prev_x[0] = X;
        end
        chk("rr_count_ge3", {7'd0, gq.size() >= 3}, 8'd1);
        if (gq.size() >= 3) begin
            chk("rr_g0", {6'd0, gq[0]}, 8'h01);
            chk("rr_g1", {6'd0, gq[1]}, 8'h02);
            chk("rr_g2", {6'd0, gq[2]}, 8'h01);
        end
        repeat (12) step(2'b00, 4'd0);

        // Longest pulse from a single one-cycle press
        xcnt = 0; dcnt = 0;
        step(2'b01, 4'd15);
        xcnt += int'(X);
        repeat (30) begin
            step(2'b00, 4'd0);
            xcnt += int'(X);
            dcnt += int'(Done);
        end
        chk("dur15_len",  8'(xcnt), 8'd16);
        chk("dur15_done", 8'(dcnt), 8'd1);

        // Dur changed mid-pulse, buttons toggled during cool-down
        xcnt = 0;
        step(2'b01, 4'd3);
        xcnt += int'(X);
        repeat (3) begin
            step(2'b00, 4'd9);
            xcnt += int'(X);
        end
        for (int i = 0; i < 8; i++) begin
            step((i % 2 == 0) ? 2'b10 : 2'b01, 4'd9);
            xcnt += int'(X);
        end
        repeat (6) begin
            step(2'b00, 4'd9);
            xcnt += int'(X);
        end
        chk("durchg_len", 8'(xcnt), 8'd4);

        // Random requests and lengths
        repeat (400) begin
            logic [1:0] rb;
            logic [3:0] rd;
            rb = 2'($urandom_range(0, 3));
            rd = 4'($urandom_range(0, 15));
            step(rb, rd);
        end
        repeat (30) step(2'b00, 4'd0);

        // Reset in the fifth ON cycle of a long pulse
        step(2'b01, 4'd15);
        repeat (4) step(2'b00, 4'd15);
        Rst = 1'b0;
        #1;
        chk("midrst_x",    {7'd0, X},    8'd0);
        chk("midrst_gnt",  {6'd0, Gnt},  8'd0);
        chk("midrst_busy", {7'd0, Busy}, 8'd0);
        @(posedge Clk);
        @(negedge Clk);
        chk("midrst_done", {7'd0, Done}, 8'd0);
        Rst = 1'b1;
        model_reset();
        step(2'b10, 4'd2);
        chk("postrst_gnt", {6'd0, Gnt}, 8'h02);
        repeat (15) step(2'b00, 4'd0);

`ifdef LASER_INTERLOCK_EN
        // Interlock trips in the third ON cycle of an 8-cycle pulse
        B = 2'b01; Dur = 4'd7;
        @(posedge Clk); @(negedge Clk);
        B = 2'b00;
        chk("ilk_on", {7'd0, X}, 8'd1);
        repeat (2) begin @(posedge Clk); @(negedge Clk); end
        Ilk = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Ilk = 1'b0;
        chk("ilk_x",     {7'd0, X},     8'd0);
        chk("ilk_abort", {7'd0, Abort}, 8'd1);
        chk("ilk_done",  {7'd0, Done},  8'd0);
        xcnt = int'(Busy); dcnt = 0;
        repeat (12) begin
            @(posedge Clk); @(negedge Clk);
            xcnt += int'(Busy);
            dcnt += int'(Done) + int'(Abort);
        end
        chk("ilk_cool_len", 8'(xcnt), 8'd8);
        chk("ilk_no_pulse", 8'(dcnt), 8'd0);
        Ilk = 1'b1; B = 2'b01;
        repeat (5) begin
            @(posedge Clk); @(negedge Clk);
            chk("ilk_block", {6'd0, Gnt}, 8'd0);
        end
        Ilk = 1'b0; B = 2'b00;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
